// File: rtl/spi_pkg.sv
// Shared widths and receiver state encoding for the SPI byte receiver.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W    = 8;
  localparam int unsigned SPI_BIT_CNT_W = 3;

  typedef enum logic {
    IDLE,
    ACTIVE
  } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with registered history for rise/fall detection.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;
  // Edges stay masked until the chain holds real pin samples, so the reset
  // value never produces a phantom edge against the live pin level.
  logic [SYNC_STAGES:0]   primed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q  <= {SYNC_STAGES{RESET_VAL}};
      prev_q   <= RESET_VAL;
      primed_q <= '0;
    end else begin
      chain_q  <= {chain_q[SYNC_STAGES-2:0], d_i};
      prev_q   <= chain_q[SYNC_STAGES-1];
      primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = primed_q[SYNC_STAGES] & sync_o & ~prev_q;
  assign fall_o = primed_q[SYNC_STAGES] & ~sync_o & prev_q;

endmodule

// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave: oversampled byte receiver with MISO echo/status shifter.
module spi_byte_rx
  import spi_pkg::*;
#(
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] RESET_BYTE  = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  output logic                  spi_miso,
  input  logic [SPI_BYTE_W-1:0] tx_byte,
  output logic [SPI_BYTE_W-1:0] byte_out,
  output logic                  byte_valid,
  output logic                  frame_err,
  output logic                  busy
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_sclk),
    .sync_o (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_cs_n),
    .sync_o (cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_mosi),
    .sync_o (mosi_s),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  rx_state_t                state_q, state_d;
  logic [SPI_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-1:0]    rx_shift_q, rx_shift_d;
  logic [SPI_BYTE_W-1:0]    tx_shift_q, tx_shift_d;
  logic [SPI_BYTE_W-1:0]    byte_q, byte_d;
  logic                     miso_q, miso_d;
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;
  logic                     reload_q, reload_d;
  logic                     busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      byte_q     <= RESET_BYTE;
      miso_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      reload_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      byte_q     <= byte_d;
      miso_q     <= miso_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      reload_q   <= reload_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    byte_d     = byte_q;
    miso_d     = miso_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    reload_d   = reload_q;
    busy_d     = ~cs_s;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = tx_byte;
          miso_d     = tx_byte[SPI_BYTE_W-1];
          err_d      = 1'b0;
          reload_d   = 1'b0;
        end
      end
      ACTIVE: begin
        // Chip-select release takes priority over any coincident SCLK edge.
        if (cs_rise) begin
          state_d    = IDLE;
          err_d      = err_q | (bit_cnt_q != '0);
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          miso_d     = 1'b0;
          reload_d   = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_d   = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
            valid_d  = 1'b1;
            reload_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (reload_q) begin
            tx_shift_d = tx_byte;
            miso_d     = tx_byte[SPI_BYTE_W-1];
            reload_d   = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
            miso_d     = tx_shift_q[SPI_BYTE_W-2];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign spi_miso   = miso_q;
  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx with a queue-based scoreboard on byte_valid.
module tb_spi_byte_rx;

  logic       clk;
  logic       rst_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       spi_miso;
  logic [7:0] tx_byte;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_err;
  logic       busy;

  int         total;
  int         bad;
  logic [7:0] exp_q[$];

  spi_byte_rx #(.SYNC_STAGES(2), .RESET_BYTE(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .spi_miso   (spi_miso),
    .tx_byte    (tx_byte),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every byte_valid pulse pops one expected byte.
  always @(negedge clk) begin
    if (byte_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got byte_out %h with no byte pending at %0t",
                 byte_out, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (byte_out !== e) begin
          bad++;
          $display("FAIL sb_byte: got %h expected %h at %0t", byte_out, e, $time);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] data, input int nbits, input int half,
                           output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = data[7-i];
      tick(half);
      got[7-i] = spi_miso;
      spi_sclk = 1'b1;
      tick(half);
      spi_sclk = 1'b0;
    end
  endtask

  logic [7:0] got, got2;
  bit         seen;

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    tx_byte  = 8'h00;
    tick(5);
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_byte_valid", {7'd0, byte_valid}, 8'h00);
    check("rst_frame_err", {7'd0, frame_err}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_miso", {7'd0, spi_miso}, 8'h00);
    rst_n = 1'b1;
    tick(10);

    // Single frame at clk/8.
    spi_cs_n = 1'b0;
    tick(8);
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 8, 4, got);
    check("busy_in_frame", {7'd0, busy}, 8'h01);
    spi_cs_n = 1'b1;
    tick(10);
    check("busy_after_frame", {7'd0, busy}, 8'h00);
    check("err_after_3c", {7'd0, frame_err}, 8'h00);
    check("byte_out_3c", byte_out, 8'h3C);

    // MISO readback of tx_byte.
    tx_byte  = 8'hA5;
    spi_cs_n = 1'b0;
    tick(8);
    exp_q.push_back(8'h00);
    send_bits(8'h00, 8, 4, got);
    check("miso_a5", got, 8'hA5);
    spi_cs_n = 1'b1;
    tick(10);
    check("miso_idle", {7'd0, spi_miso}, 8'h00);

    // Two-byte frame with tx_byte reload at the byte boundary.
    tx_byte  = 8'h11;
    spi_cs_n = 1'b0;
    tick(8);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hEF);
    seen = 1'b0;
    fork
      begin
        send_bits(8'h12, 8, 4, got);
        send_bits(8'hEF, 8, 4, got2);
      end
      begin
        for (int c = 0; c < 200 && !seen; c++) begin
          @(negedge clk);
          if (byte_valid === 1'b1) begin
            seen    = 1'b1;
            tx_byte = 8'h22;
          end
        end
        total++;
        if (!seen) begin
          bad++;
          $display("FAIL first_valid_timeout: got no byte_valid in 200 cycles, expected one");
        end
      end
    join
    check("miso_byte1", got, 8'h11);
    check("miso_byte2", got2, 8'h22);
    spi_cs_n = 1'b1;
    tick(10);
    check("byte_out_ef", byte_out, 8'hEF);

    // Truncated frame raises sticky frame_err.
    spi_cs_n = 1'b0;
    tick(8);
    send_bits(8'hFF, 5, 4, got);
    spi_cs_n = 1'b1;
    tick(10);
    check("err_partial", {7'd0, frame_err}, 8'h01);
    check("byte_out_kept", byte_out, 8'hEF);
    spi_cs_n = 1'b0;
    tick(8);
    check("err_cleared", {7'd0, frame_err}, 8'h00);
    spi_cs_n = 1'b1;
    tick(10);

    // Reset in the middle of a frame.
    spi_cs_n = 1'b0;
    tick(8);
    send_bits(8'hF0, 4, 4, got);
    rst_n = 1'b0;
    tick(2);
    check("midrst_byte_out", byte_out, 8'h00);
    check("midrst_busy", {7'd0, busy}, 8'h00);
    rst_n = 1'b1;
    tick(10);
    spi_cs_n = 1'b1;
    tick(10);
    spi_cs_n = 1'b0;
    tick(8);
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8, 4, got);
    spi_cs_n = 1'b1;
    tick(10);
    check("byte_out_81", byte_out, 8'h81);

    // SCLK activity with CS_n high is ignored; then clk/4 boundary rate.
    send_bits(8'hA7, 8, 2, got);
    send_bits(8'h3B, 8, 2, got);
    check("idle_busy", {7'd0, busy}, 8'h00);
    check("idle_miso", {7'd0, spi_miso}, 8'h00);
    check("idle_byte_out", byte_out, 8'h81);
    tick(10);
    spi_cs_n = 1'b0;
    tick(8);
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 8, 2, got);
    spi_cs_n = 1'b1;
    tick(10);
    check("byte_out_5a", byte_out, 8'h5A);
    check("err_after_5a", {7'd0, frame_err}, 8'h00);

    check("sb_drained", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
